sram_fetch_ctrl: RTL and testbench

Upstream feeder for the SRAM buffer stage. On start_sram it streams the image region (32 words = 64 x 16-bit pixels) and then the weight region (512 words = 1024 x 16-bit weights) out of fixed-latency SRAM. Each returned 32-bit word is presented on sram_data with a valid strobe and a region/index tag. sram_done pulses once when the last word has been delivered, so the buffer stage can unpack words into its image and weight arrays.

---
 rtl/sram_fetch_pkg.sv | 25 ++
 rtl/rd_tag_pipe.sv | 37 +++
 rtl/sram_fetch_ctrl.sv | 155 +++++++++++++++
 tb/tb_sram_fetch_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/sram_fetch_pkg.sv
// Shared types for the SRAM fetch controller.
//   state_e : controller FSM states
//   tag_t   : per-issue tag that travels beside each read until its data returns
//   IMG_WORDS_DEF / WGT_WORDS_DEF : default region sizes in 32-bit words
package sram_fetch_pkg;

  localparam int IMG_WORDS_DEF = 32;
  localparam int WGT_WORDS_DEF = 512;
  localparam int IDX_W         = 9;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH_IMG = 3'd1,
    FETCH_WGT = 3'd2,
    DRAIN     = 3'd3,
    DONE      = 3'd4
  } state_e;

  typedef struct packed {
    logic             valid;
    logic             is_wgt;
    logic [IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// RD_LAT-deep shift register of read tags. A tag entering on the cycle a
// read is issued leaves on the cycle that read's data is on mem_rdata.
//   clk, n_rst : clock, async active-low reset (clears every stage)
//   tag_i      : tag of the read issued this cycle (valid=0 when idle)
//   tag_o      : tag aligned with the current mem_rdata
//   busy_o     : some stage still holds a valid tag
module rd_tag_pipe
  import sram_fetch_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic clk,
  input  logic n_rst,
  input  tag_t tag_i,
  output tag_t tag_o,
  output logic busy_o
);

  tag_t [RD_LAT-1:0] stg_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      stg_q <= '0;
    end else begin
      stg_q[0] <= tag_i;
      for (int i = 1; i < RD_LAT; i++) stg_q[i] <= stg_q[i-1];
    end
  end

  assign tag_o = stg_q[RD_LAT-1];

  always_comb begin
    busy_o = 1'b0;
    for (int i = 0; i < RD_LAT; i++) busy_o = busy_o | stg_q[i].valid;
  end

endmodule

// File: rtl/sram_fetch_ctrl.sv
// Streams the image region then the weight region out of a fixed-latency
// SRAM and hands each returned word to the buffer stage with a region/index
// tag. One read is issued per cycle with no gap between the two regions.
//   clk, n_rst           : clock, async active-low reset
//   start_sram           : start request, honoured only in IDLE
//   img_base, wgt_base   : region base word addresses, latched at start
//   mem_ren, mem_addr    : SRAM read request (addr holds when idle)
//   mem_rdata            : SRAM data, RD_LAT cycles after mem_ren
//   sram_data, data_valid, data_is_wgt, word_idx : registered return stream
//   sram_done            : one-cycle pulse after the final data_valid
//   busy                 : first issue cycle through the sram_done cycle
module sram_fetch_ctrl
  import sram_fetch_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int RD_LAT    = 2,
  parameter int IMG_WORDS = IMG_WORDS_DEF,
  parameter int WGT_WORDS = WGT_WORDS_DEF
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start_sram,
  input  logic [ADDR_W-1:0] img_base,
  input  logic [ADDR_W-1:0] wgt_base,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       sram_data,
  output logic              data_valid,
  output logic              data_is_wgt,
  output logic [IDX_W-1:0]  word_idx,
  output logic              sram_done,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] img_base_q, img_base_d;
  logic [ADDR_W-1:0] wgt_base_q, wgt_base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  tag_t              issue_q, issue_d;
  tag_t              ret_tag;
  logic              pipe_busy;
  logic              fetch_d;
  logic [31:0]       data_q;
  logic              dv_q, isw_q, done_q, busy_q;
  logic [IDX_W-1:0]  idx_q;

  // cnt_q is the index of the read being issued this cycle (== issue_q.idx).
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    img_base_d = img_base_q;
    wgt_base_d = wgt_base_q;
    unique case (state_q)
      IDLE: begin
        if (start_sram) begin
          state_d    = FETCH_IMG;
          cnt_d      = '0;
          img_base_d = img_base;
          wgt_base_d = wgt_base;
        end
      end
      FETCH_IMG: begin
        if (cnt_q == IDX_W'(IMG_WORDS - 1)) begin
          state_d = FETCH_WGT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      FETCH_WGT: begin
        if (cnt_q == IDX_W'(WGT_WORDS - 1)) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      // Once the pipe is empty the last tag has already been registered out.
      DRAIN:   if (!pipe_busy) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request outputs are registered from the next state so the first read
  // goes out in the cycle right after start is sampled.
  always_comb begin
    fetch_d        = (state_d == FETCH_IMG) || (state_d == FETCH_WGT);
    issue_d.valid  = fetch_d;
    issue_d.is_wgt = (state_d == FETCH_WGT);
    issue_d.idx    = cnt_d;
    addr_d         = addr_q;
    if (fetch_d)
      addr_d = ((state_d == FETCH_WGT) ? wgt_base_d : img_base_d) + ADDR_W'(cnt_d);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      img_base_q <= '0;
      wgt_base_q <= '0;
      addr_q     <= '0;
      issue_q    <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      img_base_q <= img_base_d;
      wgt_base_q <= wgt_base_d;
      addr_q     <= addr_d;
      issue_q    <= issue_d;
      done_q     <= (state_d == DONE);
      busy_q     <= (state_d != IDLE);
    end
  end

  rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
    .clk    (clk),
    .n_rst  (n_rst),
    .tag_i  (issue_q),
    .tag_o  (ret_tag),
    .busy_o (pipe_busy)
  );

  // Return register: data and tag captured together; all hold while idle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      data_q <= '0;
      dv_q   <= 1'b0;
      isw_q  <= 1'b0;
      idx_q  <= '0;
    end else begin
      dv_q <= ret_tag.valid;
      if (ret_tag.valid) begin
        data_q <= mem_rdata;
        isw_q  <= ret_tag.is_wgt;
        idx_q  <= ret_tag.idx;
      end
    end
  end

  assign mem_ren     = issue_q.valid;
  assign mem_addr    = addr_q;
  assign sram_data   = data_q;
  assign data_valid  = dv_q;
  assign data_is_wgt = isw_q;
  assign word_idx    = idx_q;
  assign sram_done   = done_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_sram_fetch_ctrl.sv
// Bench for sram_fetch_ctrl. Three instances at RD_LAT = 2, 1, 4 share the
// clock, reset and base inputs; each has its own start and SRAM model.
// Cycle k is the period ending at edge k; start is sampled at edge 0.
module tb_sram_fetch_ctrl;

  logic              clk = 1'b0;
  logic              n_rst;
  logic [15:0]       img_base, wgt_base;
  logic [31:0]       key;
  logic [2:0]        start_r;
  logic [2:0]        ren_w, dv_w, isw_w, done_w, busy_w;
  logic [2:0][15:0]  addr_w;
  logic [2:0][31:0]  rdata_w, data_w;
  logic [2:0][8:0]   idx_w;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 1) ? 1 : (g == 2) ? 4 : 2;
    logic [31:0] dl [4];

    sram_fetch_ctrl #(.ADDR_W(16), .RD_LAT(L)) u_dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .start_sram  (start_r[g]),
      .img_base    (img_base),
      .wgt_base    (wgt_base),
      .mem_ren     (ren_w[g]),
      .mem_addr    (addr_w[g]),
      .mem_rdata   (rdata_w[g]),
      .sram_data   (data_w[g]),
      .data_valid  (dv_w[g]),
      .data_is_wgt (isw_w[g]),
      .word_idx    (idx_w[g]),
      .sram_done   (done_w[g]),
      .busy        (busy_w[g])
    );

    // SRAM model: word = addr ^ key, garbage when no read was issued.
    always @(posedge clk) begin
      dl[0] <= ren_w[g] ? ({16'h0, addr_w[g]} ^ key) : $urandom;
      for (int i = 1; i < 4; i++) dl[i] <= dl[i-1];
    end
    assign rdata_w[g] = dl[L-1];
  end

  // Word i of a run (0..543): image words first, then weights, 16-bit wrap.
  function automatic logic [15:0] word_addr(input int i, input logic [15:0] ib,
                                            input logic [15:0] wb);
    if (i < 32) return ib + 16'(i);
    return wb + 16'(i - 32);
  endfunction

  task automatic run_check(input int g, input int lat, input logic [15:0] ib,
                           input logic [15:0] wb, input logic [31:0] k,
                           input int tail, input int p0, input int p1,
                           input int p2, input string nm);
    int last, j;
    logic e_ren, e_dv;
    logic [15:0] ea;
    logic [31:0] ed;
    last = lat + 546;
    img_base = ib; wgt_base = wb; key = k;
    @(negedge clk); start_r[g] = 1'b1;
    for (int c = 1; c <= last + tail; c++) begin
      @(negedge clk);
      start_r[g] = (c == p0) || (c == p1) || (c == p2);
      e_ren = (c <= 544);
      ea = word_addr(e_ren ? c - 1 : 543, ib, wb);
      checks++;
      if (ren_w[g] !== e_ren || addr_w[g] !== ea) begin
        errors++;
        $display("FAIL %s issue c=%0d ren/addr got %b/%h exp %b/%h", nm, c, ren_w[g], addr_w[g], e_ren, ea);
      end
      e_dv = (c >= lat + 2) && (c <= lat + 545);
      checks++;
      if (dv_w[g] !== e_dv) begin
        errors++;
        $display("FAIL %s data_valid c=%0d got %b exp %b", nm, c, dv_w[g], e_dv);
      end
      if (c >= lat + 2) begin
        j = e_dv ? c - lat - 2 : 543;
        ed = {16'h0, word_addr(j, ib, wb)} ^ k;
        checks++;
        if (data_w[g] !== ed) begin
          errors++;
          $display("FAIL %s sram_data c=%0d got %h exp %h", nm, c, data_w[g], ed);
        end
        if (e_dv) begin
          checks++;
          if (isw_w[g] !== (j >= 32) || idx_w[g] !== 9'((j < 32) ? j : j - 32)) begin
            errors++;
            $display("FAIL %s tag c=%0d is_wgt/idx got %b/%0d exp %b/%0d", nm, c, isw_w[g], idx_w[g],
                     (j >= 32), (j < 32) ? j : j - 32);
          end
        end
      end
      checks++;
      if (done_w[g] !== (c == last) || busy_w[g] !== (c <= last)) begin
        errors++;
        $display("FAIL %s done/busy c=%0d got %b/%b exp %b/%b", nm, c, done_w[g], busy_w[g], (c == last), (c <= last));
      end
    end
  endtask

  task automatic test_reset;
    n_rst = 1'b0; start_r = '0; img_base = '0; wgt_base = '0; key = '0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      checks++;
      if ({ren_w[g], addr_w[g], data_w[g], dv_w[g], isw_w[g], idx_w[g], done_w[g], busy_w[g]} !== 62'd0) begin
        errors++;
        $display("FAIL reset inst%0d outputs got %b/%h/%h/%b/%b/%0d/%b/%b exp all 0", g, ren_w[g], addr_w[g],
                 data_w[g], dv_w[g], isw_w[g], idx_w[g], done_w[g], busy_w[g]);
      end
    end
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy_w !== 3'b000 || ren_w !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset busy/ren got %b/%b exp 000/000", busy_w, ren_w);
    end
  endtask

  task automatic test_basic;
    run_check(0, 2, 16'h0100, 16'h2000, 32'hA5A5_0000, 6, -1, -1, -1, "basic");
  endtask

  task automatic test_random;
    for (int r = 0; r < 2; r++)
      run_check(0, 2, 16'($urandom), 16'($urandom), $urandom, 3, -1, -1, -1, "random");
  endtask

  task automatic test_wrap;
    run_check(0, 2, 16'hFFF0, 16'($urandom), $urandom, 3, -1, -1, -1, "wrap_img");
    run_check(0, 2, 16'h0100, 16'hFF00, $urandom, 3, -1, -1, -1, "wrap_wgt");
  endtask

  task automatic test_restart_ignored;
    run_check(0, 2, 16'($urandom), 16'($urandom), $urandom, 6, 10, 300, 548, "restart_ign");
  endtask

  task automatic test_back_to_back;
    run_check(0, 2, 16'($urandom), 16'($urandom), $urandom, 0, 10, 300, 548, "b2b_first");
    run_check(0, 2, 16'($urandom), 16'($urandom), $urandom, 4, -1, -1, -1, "b2b_second");
  endtask

  task automatic test_reset_midrun;
    img_base = 16'($urandom); wgt_base = 16'($urandom); key = $urandom;
    @(negedge clk); start_r[0] = 1'b1;
    for (int c = 1; c < 200; c++) begin
      @(negedge clk); start_r[0] = 1'b0;
    end
    @(negedge clk);
    n_rst = 1'b0;
    for (int c = 200; c < 205; c++) begin
      if (c == 200) #1; else @(negedge clk);
      checks++;
      if ({ren_w[0], addr_w[0], data_w[0], dv_w[0], isw_w[0], idx_w[0], done_w[0], busy_w[0]} !== 62'd0) begin
        errors++;
        $display("FAIL midrun_reset c=%0d outputs got %b/%h/%h/%b/%b/%0d/%b/%b exp all 0", c, ren_w[0],
                 addr_w[0], data_w[0], dv_w[0], isw_w[0], idx_w[0], done_w[0], busy_w[0]);
      end
    end
    @(negedge clk); n_rst = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      checks++;
      if ({ren_w[0], dv_w[0], done_w[0], busy_w[0]} !== 4'b0000) begin
        errors++;
        $display("FAIL post_reset_quiet c=%0d ren/dv/done/busy got %b/%b/%b/%b exp 0/0/0/0", c, ren_w[0],
                 dv_w[0], done_w[0], busy_w[0]);
      end
    end
    run_check(0, 2, 16'($urandom), 16'($urandom), $urandom, 3, -1, -1, -1, "after_reset");
  endtask

  task automatic test_rd_lat;
    run_check(1, 1, 16'($urandom), 16'($urandom), $urandom, 4, -1, -1, -1, "rd_lat1");
    run_check(2, 4, 16'($urandom), 16'($urandom), $urandom, 4, -1, -1, -1, "rd_lat4");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_wrap();
    test_restart_ignored();
    test_back_to_back();
    test_reset_midrun();
    test_rd_lat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
